// File: rtl/rr_quantum_arbiter.sv
// Round-robin arbiter for one shared resource with a per-grant hold quantum.
// A holder keeps its grant while requesting. Under contention it is handed off
// after QUANTUM cycles, and the handoff pulses preempt.
module rr_quantum_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned QUANTUM = 8,
    localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          preempt
);

    localparam int unsigned CW = $clog2(QUANTUM) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(QUANTUM - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        state_q,   state_d;
    logic [N-1:0]  gnt_q,     gnt_d;
    logic [IW-1:0] gnt_id_q,  gnt_id_d;
    logic [IW-1:0] last_id_q, last_id_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          preempt_q, preempt_d;

    logic          released;
    logic          expired;
    logic          arbitrate;
    logic          found;
    logic [IW-1:0] win_id;
    logic [N-1:0]  win_oh;
    int unsigned   idx;

    // Release / expiry detection and the round-robin search starting after last_id.
    always_comb begin
        released  = (state_q == ST_GRANT) && ((req & gnt_q) == '0);
        expired   = (state_q == ST_GRANT) && (cnt_q == CNT_MAX) && ((req & ~gnt_q) != '0);
        arbitrate = (state_q == ST_IDLE) || released || expired;
        found     = 1'b0;
        win_id    = '0;
        win_oh    = '0;
        idx       = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = int'(last_id_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[IW'(idx)]) begin
                found  = 1'b1;
                win_id = IW'(idx);
                win_oh = N'(1) << idx;
            end
        end
    end

    // Next-state logic: arbitrate, hold with saturating count, or fall idle.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        if (arbitrate) begin
            if (found) begin
                state_d   = ST_GRANT;
                gnt_d     = win_oh;
                gnt_id_d  = win_id;
                last_id_d = win_id;
                cnt_d     = '0;
                // Release wins over expiry when both happen on the same edge.
                preempt_d = expired && !released;
            end else begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                cnt_d    = '0;
            end
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State and output registers; last_id resets to N-1 so the first search starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_id_q <= IW'(N - 1);
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q == ST_GRANT);
    assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// Bench for rr_quantum_arbiter (N=4, QUANTUM=4): directed scenarios plus random
// request traffic, checked every cycle against a queue-free behavioural model.
module tb_rr_quantum_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned Q = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       preempt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: who holds, who held last, how many cycles the grant has been visible.
    int m_holder = -1;
    int m_last   = N - 1;
    int m_held   = 0;
    bit m_pre    = 1'b0;

    rr_quantum_arbiter #(.N(N), .QUANTUM(Q)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [3:0] r);
        bit rel;
        bit oth;
        bit exp;
        int w;
        rel = 1'b0;
        oth = 1'b0;
        if (m_holder >= 0) rel = !r[m_holder];
        for (int k = 0; k < int'(N); k++) begin
            if (k != m_holder && r[k]) oth = 1'b1;
        end
        exp = (m_holder >= 0) && (m_held >= int'(Q)) && oth;
        if (m_holder < 0 || rel || exp) begin
            w = -1;
            for (int k = 1; k <= int'(N); k++) begin
                if (w < 0 && r[(m_last + k) % int'(N)]) w = (m_last + k) % int'(N);
            end
            if (w >= 0) begin
                m_pre    = exp && !rel;
                m_holder = w;
                m_last   = w;
                m_held   = 1;
            end else begin
                m_holder = -1;
                m_held   = 0;
                m_pre    = 1'b0;
            end
        end else begin
            m_held = m_held + 1;
            m_pre  = 1'b0;
        end
    endtask

    // Model advances on the same edges as the design.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_holder = -1;
            m_last   = N - 1;
            m_held   = 0;
            m_pre    = 1'b0;
        end else begin
            model_step(req);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        if (rst_n) begin
            chk("model_gnt",     32'(gnt),     (m_holder >= 0) ? (32'(1) << m_holder) : 32'(0));
            chk("model_gnt_id",  32'(gnt_id),  (m_holder >= 0) ? 32'(m_holder) : 32'(0));
            chk("model_busy",    32'(busy),    32'(m_holder >= 0));
            chk("model_preempt", 32'(preempt), 32'(m_pre));
        end
    endtask

    // Advance one cycle and compare against the model mid-cycle.
    task automatic step();
        @(negedge clk);
        model_check();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_preempt", 32'(preempt), 32'h0);
        rst_n = 1'b1;

        // Full contention from reset: 0001,0010,0100,1000,0001 for 4 cycles each.
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("contention_gnt", 32'(gnt), 32'(1) << ((c / 4) % 4));
            chk("contention_preempt", 32'(preempt), 32'((c % 4 == 0) && (c >= 4)));
        end
        req = 4'b0000;
        step();
        chk("removal_gnt", 32'(gnt), 32'h0);
        chk("removal_busy", 32'(busy), 32'h0);

        // Sole holder keeps the grant with no preempt.
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("sole_gnt", 32'(gnt), 32'h4);
            chk("sole_gnt_id", 32'(gnt_id), 32'h2);
            chk("sole_preempt", 32'(preempt), 32'h0);
        end
        req = 4'b0000;
        step();

        // Release handoff while cnt=1, then the new holder runs a full quantum.
        req = 4'b0011;
        step();
        chk("handoff_first", 32'(gnt), 32'h1);
        step();
        req = 4'b0010;
        step();
        chk("handoff_gnt", 32'(gnt), 32'h2);
        chk("handoff_preempt", 32'(preempt), 32'h0);
        req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("handoff_hold", 32'(gnt), 32'h2);
        end
        step();
        chk("expiry_gnt", 32'(gnt), 32'h1);
        chk("expiry_preempt", 32'(preempt), 32'h1);

        // Release in the same cycle the quantum expires counts as a release.
        repeat (3) step();
        req = 4'b0010;
        step();
        chk("simul_gnt", 32'(gnt), 32'h2);
        chk("simul_preempt", 32'(preempt), 32'h0);

        // Fairness wrap: after master 3, master 0 goes first, then master 3 again.
        req = 4'b1000;
        step();
        chk("wrap_m3", 32'(gnt), 32'h8);
        req = 4'b0001;
        step();
        chk("wrap_m0", 32'(gnt), 32'h1);
        req = 4'b1001;
        step();
        step();
        chk("wrap_m0_hold", 32'(gnt), 32'h1);
        req = 4'b1000;
        step();
        chk("wrap_m3_again", 32'(gnt), 32'h8);
        chk("wrap_m3_id", 32'(gnt_id), 32'h3);

        // Asynchronous reset mid-grant clears outputs before any clock edge.
        req = 4'b0010;
        step();
        chk("pre_reset_gnt", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("async_rst_preempt", 32'(preempt), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_gnt_id", 32'(gnt_id), 32'h0);

        // Random traffic with sticky requests so contention and quanta play out.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 4'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_quantum_arbiter.md
# rr_quantum_arbiter

- N-requester round-robin arbiter for a single shared resource; the successor to the fixed-priority three-master arbiter.
- A requester holds its grant while its request stays high, but holds it for at most QUANTUM consecutive cycles when other requesters are waiting.
- Sits between the masters' request lines and the resource's access mux, and drives the mux select directly.

## Interface
- N, 4: number of requesters, range 1..16.
- QUANTUM, 8: maximum consecutive grant cycles under contention, range 1..256.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request per master; level-sensitive, sampled at rising edge.
- gnt  output  N  one-hot grant (or all-zero); registered.
- gnt_id  output  max(1,$clog2(N))  index of the granted master; valid when busy=1, otherwise 0.
- busy  output  1  high when any gnt bit is set.
- preempt  output  1  one-cycle pulse, high in the first cycle of a grant caused by quantum expiry.

## Operation
- States:
  - IDLE: gnt=0.
  - GRANT: exactly one gnt bit set.
- Internal state:
  - last_id: index of the most recent grant.
  - cnt: hold counter, width $clog2(QUANTUM)+1, saturating at QUANTUM-1.
- released = busy && !req[gnt_id].
- expired = busy && cnt==QUANTUM-1 && (req with bit gnt_id masked) != 0.
- Arbitration happens at a rising edge when any of these holds: state IDLE, released, or expired.
- Round-robin search:
  - Examine indices last_id+1, last_id+2, … modulo N; the first with req=1 wins.
  - The search includes last_id itself as the final candidate.
  - If none are found, go to IDLE with gnt=0 and gnt_id=0.
- On a new grant:
  - gnt = one-hot(winner), gnt_id = winner, last_id = winner, cnt = 0.
  - preempt = 1 only if the arbitration was triggered by expired and not by released; otherwise preempt = 0.
- While holding without arbitration: cnt increments, saturating at QUANTUM-1, and preempt = 0.
- Release takes priority over expiry. If the holder drops req in the same cycle cnt reaches QUANTUM-1, this is a release and preempt=0.
- Sole requester: if only the holder requests, it keeps the grant indefinitely. cnt saturates and there is no preempt.
- Released holder: its req is low, so it cannot be re-granted at the release edge.
- Dropped request: a holder that drops req for even one cycle loses the grant and re-queues in round-robin order.
- N=1: expired is never true; the block behaves as grant-while-requesting.
- QUANTUM=1: under contention, grants rotate every cycle with preempt high on each handoff.
- At most one gnt bit is ever set. gnt, gnt_id and busy are mutually consistent in every cycle.

## Timing
- Reset (async assert; deassert synchronised externally) sets:
  - gnt=0, gnt_id=0, busy=0, preempt=0.
  - cnt=0, last_id=N-1, so the first search starts at index 0.
- Reset mid-grant clears all outputs immediately, without waiting for a clock edge.
- Request-to-grant latency is 1 cycle: req high at edge k gives gnt high after edge k.
- Release handoff has zero idle cycles: if the holder's req is low at edge k and another req is high, the new gnt appears after edge k.
- Grant removal: with the holder's req low at edge k and no other requester, gnt=0 after edge k.
- Maximum hold under contention is QUANTUM cycles. The grant is visible for cycles with cnt=0..QUANTUM-1, and the handoff occurs at the edge where cnt=QUANTUM-1.
- Worst-case wait for any continuously requesting master is (N-1)*QUANTUM+1 cycles.
- preempt is registered and aligned with the first cycle of the new grant.

## Test plan
All scenarios use N=4, QUANTUM=4.
- Reset: assert rst_n=0 mid-simulation with gnt=0010.
  - Required: gnt=0000, busy=0, gnt_id=0 and preempt=0 immediately.
  - Required: first req=1111 after reset is granted to master 0.
- Sole holder: req=0100 held for 20 cycles.
  - Required: gnt=0100 from the cycle after req rises, gnt_id=2, busy=1 throughout, preempt never asserted.
- Full contention: req=1111 held constant.
  - Required: gnt sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles.
  - Required: preempt=1 in the first cycle of every grant after the first.
- Release handoff: req=0011, gnt=0001; drop req[0] while cnt=1.
  - Required: gnt=0010 on the next cycle, no idle cycle, preempt=0, cnt restarts at 0.
- Simultaneous release and expiry: req=0011, gnt=0001; drop req[0] exactly when cnt=3.
  - Required: gnt=0010, preempt=0.
- Fairness wrap: last grant to master 3, then req[3] dropped, giving req=1001 with req[3] then re-raised.
  - Required: next grant goes to master 0 (gnt=0001), not master 3.
  - Required: after master 0 releases, master 3 is granted.
